alu_writeback: RTL and testbench

//  Consumes each ALU operation (result + C/Z/S) and holds the architectural flag register.

---
 rtl/alu_writeback.sv | 129 ++++++++++++
 tb/tb_alu_writeback.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU result writeback stage with 2-entry skid buffer and flag register
module alu_writeback #(
  parameter int DATA_WIDTH = 8,
  parameter int DEST_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_c,
  input  logic                  in_z,
  input  logic                  in_s,
  input  logic [DEST_WIDTH-1:0] in_dest,
  input  logic                  in_reg_we,
  input  logic                  in_flag_we,
  input  logic                  flags_load,
  input  logic [2:0]            flags_in,
  output logic                  flag_c,
  output logic                  flag_z,
  output logic                  flag_s,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DEST_WIDTH-1:0] out_dest,
  output logic                  out_reg_we
);

  localparam int ENTRY_WIDTH = DATA_WIDTH + DEST_WIDTH + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [ENTRY_WIDTH-1:0] in_entry;
  logic [ENTRY_WIDTH-1:0] out_entry;
  logic [ENTRY_WIDTH-1:0] skid_entry;
  logic                   accept;
  logic                   complete;
  logic [2:0]             flags;

  assign in_entry = {in_reg_we, in_dest, in_result};
  assign accept   = in_valid && in_ready;
  assign complete = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (accept) state_next = ONE;
      ONE: begin
        if (accept && !complete) begin
          state_next = FULL;
        end else if (!accept && complete) begin
          state_next = EMPTY;
        end
      end
      FULL: if (complete) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  // Handshake outputs decode only the registered state, so in_ready never sees out_ready.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state)
      EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
      end
      FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_entry  <= '0;
      skid_entry <= '0;
    end else begin
      if (accept && (state == EMPTY || (state == ONE && complete))) begin
        out_entry <= in_entry;
      end else if (state == FULL && complete) begin
        out_entry <= skid_entry;
      end
      if (accept && state == ONE && !complete) begin
        skid_entry <= in_entry;
      end
    end
  end

  assign {out_reg_we, out_dest, out_data} = out_entry;

  // A flag-writing accept outranks a direct load; nothing touches flags while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= 3'b000;
    end else if (accept && in_flag_we) begin
      flags <= {in_c, in_z, in_s};
    end else if (flags_load && in_ready) begin
      flags <= flags_in;
    end
  end

  assign {flag_c, flag_z, flag_s} = flags;

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - scoreboard testbench for alu_writeback
module tb_alu_writeback;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_result;
  logic       in_c, in_z, in_s;
  logic [1:0] in_dest;
  logic       in_reg_we;
  logic       in_flag_we;
  logic       flags_load;
  logic [2:0] flags_in;
  logic       flag_c, flag_z, flag_s;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_dest;
  logic       out_reg_we;

  int         checks = 0;
  int         errors = 0;
  bit         started = 1'b0;
  logic [10:0] sb_q[$];
  logic [2:0]  exp_flags = 3'b000;

  alu_writeback #(.DATA_WIDTH(8), .DEST_WIDTH(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_c(in_c), .in_z(in_z), .in_s(in_s), .in_dest(in_dest),
    .in_reg_we(in_reg_we), .in_flag_we(in_flag_we),
    .flags_load(flags_load), .flags_in(flags_in),
    .flag_c(flag_c), .flag_z(flag_z), .flag_s(flag_s),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dest(out_dest), .out_reg_we(out_reg_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] r, input logic [1:0] d,
                       input logic rwe, input logic fwe, input logic [2:0] czs,
                       input logic fl, input logic [2:0] fin, input logic ordy);
    in_valid   = v;
    in_result  = r;
    in_dest    = d;
    in_reg_we  = rwe;
    in_flag_we = fwe;
    {in_c, in_z, in_s} = czs;
    flags_load = fl;
    flags_in   = fin;
    out_ready  = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, ordy);
  endtask

  // Reference model: a FIFO of at most two pending entries plus a flag register.
  always @(negedge clk) begin
    int  held;
    bit  take;
    logic [10:0] e;
    if (started) begin
      held = sb_q.size();
      chk("in_ready", {31'd0, in_ready}, {31'd0, held < 2});
      chk("out_valid", {31'd0, out_valid}, {31'd0, held != 0});
      chk("flags", {29'd0, flag_c, flag_z, flag_s}, {29'd0, exp_flags});
      if (reset) begin
        sb_q.delete();
        exp_flags = 3'b000;
      end else begin
        take = in_valid && (held < 2);
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_output", {21'd0, out_reg_we, out_dest, out_data}, 32'hFFFF_FFFF);
          end else begin
            e = sb_q.pop_front();
            chk("out_entry", {21'd0, out_reg_we, out_dest, out_data}, {21'd0, e});
          end
        end
        if (take) sb_q.push_back({in_reg_we, in_dest, in_result});
        if (take && in_flag_we) exp_flags = {in_c, in_z, in_s};
        else if (flags_load && held < 2) exp_flags = flags_in;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    idle(1'b0);
    idle(1'b0);
    started = 1'b1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_word", {21'd0, out_reg_we, out_dest, out_data}, 32'd0);
    chk("reset_flags", {29'd0, flag_c, flag_z, flag_s}, 32'd0);
    reset = 1'b0;
    idle(1'b0);

    drive(1'b1, 8'h3C, 2'd2, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_out_data", {24'd0, out_data}, 32'h3C);
    chk("t1_out_dest", {30'd0, out_dest}, 32'd2);
    idle(1'b1);

    drive(1'b1, 8'h01, 2'd1, 1'b0, 1'b1, 3'b101, 1'b0, 3'b000, 1'b1);
    chk("t2_flags_set", {29'd0, flag_c, flag_z, flag_s}, 32'b101);
    drive(1'b1, 8'h02, 2'd1, 1'b1, 1'b0, 3'b010, 1'b0, 3'b000, 1'b1);
    chk("t2_flags_hold", {29'd0, flag_c, flag_z, flag_s}, 32'b101);
    idle(1'b1);

    drive(1'b1, 8'h11, 2'd0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
    drive(1'b1, 8'h22, 2'd1, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
    chk("t3_full_in_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 8'h33, 2'd2, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
    chk("t3_stall_data", {24'd0, out_data}, 32'h11);
    drive(1'b1, 8'h33, 2'd2, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1);
    drive(1'b1, 8'h33, 2'd2, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("t3_drained", sb_q.size(), 32'd0);

    drive(1'b1, 8'h44, 2'd3, 1'b0, 1'b1, 3'b110, 1'b1, 3'b010, 1'b1);
    chk("t4_accept_wins", {29'd0, flag_c, flag_z, flag_s}, 32'b110);
    drive(1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 3'b000, 1'b1, 3'b010, 1'b1);
    chk("t4_load_alone", {29'd0, flag_c, flag_z, flag_s}, 32'b010);

    drive(1'b1, 8'h55, 2'd0, 1'b1, 1'b1, 3'b111, 1'b0, 3'b000, 1'b0);
    drive(1'b1, 8'h66, 2'd1, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 1'b0);
    chk("t5_full", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    idle(1'b0);
    reset = 1'b0;
    chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_flags", {29'd0, flag_c, flag_z, flag_s}, 32'd0);
    idle(1'b1);

    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 8'(i), 2'(i), 1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1);
    end
    idle(1'b1);
    idle(1'b1);

    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom), 1'($urandom),
            1'($urandom), 3'($urandom), 1'($urandom_range(0, 3) == 0), 3'($urandom),
            1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("final_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
